// File: rtl/cs_pkg.sv
// Shared state type and rotation helpers for the cyclic-shift/XOR erasure encoder.
package cs_pkg;

    localparam int CS_MAX_WIDTH = 64;
    localparam int CS_IDX_BITS  = 6;

    typedef enum logic [0:0] {
        S_DATA   = 1'b0,
        S_PARITY = 1'b1
    } cs_enc_state_e;

    // Constant-amount rotate; only the low 'width' bits of x/result are meaningful.
    function automatic logic [CS_MAX_WIDTH-1:0] rotl(
        input logic [CS_MAX_WIDTH-1:0] x,
        input int                      s,
        input int                      width
    );
        logic [CS_MAX_WIDTH-1:0] y;
        y = '0;
        for (int b = 0; b < width; b++) begin
            y[CS_IDX_BITS'((b + s) % width)] = x[CS_IDX_BITS'(b)];
        end
        return y;
    endfunction

    function automatic int shift_amt(input int r, input int j, input int width);
        return ((r + 1) * (j + 1)) % width;
    endfunction

endpackage

// File: rtl/cs_parity_row.sv
// One parity accumulator row: each accepted data beat is rotated by its column's
// amount for this row and XORed into acc, which restarts on column 0.
module cs_parity_row
    import cs_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int K     = 2,
    parameter int ROW   = 0,
    parameter int IDXW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [IDXW-1:0]  j,
    input  logic [WIDTH-1:0] s_data,
    output logic [WIDTH-1:0] acc
);

    logic [WIDTH-1:0] rot [K];
    logic [WIDTH-1:0] rot_sel;

    for (genvar c = 0; c < K; c++) begin : g_col
        cyclic_shift #(
            .WIDTH    (WIDTH),
            .SHIFT_AMT(shift_amt(ROW, c, WIDTH))
        ) u_shift (
            .x(s_data),
            .y(rot[c])
        );
    end

    always_comb begin
        rot_sel = '0;
        for (int c = 0; c < K; c++) begin
            if (j == IDXW'(c)) rot_sel = rot[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= ((j == '0) ? '0 : acc) ^ rot_sel;
        end
    end

endmodule

// File: rtl/cyclic_shift.sv
// Fixed-amount cyclic left rotate of a WIDTH-bit symbol; reduces to pure wiring.
module cyclic_shift
    import cs_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int SHIFT_AMT = 1
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = WIDTH'(rotl(CS_MAX_WIDTH'(x), SHIFT_AMT, WIDTH));

endmodule

// File: rtl/cs_stream_encoder.sv
// Streaming systematic (K, K+M) cyclic-shift/XOR erasure encoder: forwards K data
// symbols unchanged, then optionally appends M parity symbols per block.
module cs_stream_encoder
    import cs_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int K     = 2,
    parameter int M     = 1,
    parameter int IDXW  = (K + M > 2) ? $clog2(K + M) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             parity_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [IDXW-1:0]  m_idx,
    output logic             m_last
);

    localparam logic [0:0] ST_DATA   = 1'(S_DATA);
    localparam logic [0:0] ST_PARITY = 1'(S_PARITY);

    if (WIDTH < 2 || K < 1 || M < 1) begin : g_param_check
        $error("cs_stream_encoder: requires WIDTH>=2, K>=1, M>=1");
    end

    logic [0:0]       state;
    logic [IDXW-1:0]  j;
    logic [IDXW-1:0]  r;
    logic             pen_q;
    logic             pen_eff;
    logic             out_free;
    logic             accept;
    logic             j_last;
    logic             r_last;
    logic [WIDTH-1:0] acc [M];
    logic [WIDTH-1:0] parity_sel;

    assign out_free = !m_valid || m_ready;
    assign s_ready  = (state == ST_DATA) && out_free;
    assign accept   = s_valid && s_ready;
    assign j_last   = (j == IDXW'(K - 1));
    assign r_last   = (r == IDXW'(M - 1));
    // With a single data symbol the block's first beat is also its last, so pen_q is not yet loaded.
    assign pen_eff  = (K == 1) ? parity_en : pen_q;

    for (genvar g = 0; g < M; g++) begin : g_row
        cs_parity_row #(
            .WIDTH(WIDTH),
            .K    (K),
            .ROW  (g),
            .IDXW (IDXW)
        ) u_row (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (accept),
            .j     (j),
            .s_data(s_data),
            .acc   (acc[g])
        );
    end

    always_comb begin
        parity_sel = '0;
        for (int i = 0; i < M; i++) begin
            if (r == IDXW'(i)) parity_sel = acc[i];
        end
    end

    // Output register doubles as the only pipeline stage; it only changes when free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_DATA;
            j       <= '0;
            r       <= '0;
            pen_q   <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_idx   <= '0;
            m_last  <= 1'b0;
        end else begin
            case (state)
                ST_DATA: begin
                    if (accept) begin
                        m_data  <= s_data;
                        m_idx   <= j;
                        m_valid <= 1'b1;
                        if (j == '0) pen_q <= parity_en;
                        if (j_last) begin
                            if (pen_eff) begin
                                m_last <= 1'b0;
                                state  <= ST_PARITY;
                            end else begin
                                m_last <= 1'b1;
                                j      <= '0;
                            end
                        end else begin
                            m_last <= 1'b0;
                            j      <= j + 1'b1;
                        end
                    end else if (out_free) begin
                        m_valid <= 1'b0;
                    end
                end
                ST_PARITY: begin
                    if (out_free) begin
                        m_data  <= parity_sel;
                        m_idx   <= IDXW'(K) + r;
                        m_valid <= 1'b1;
                        m_last  <= r_last;
                        if (r_last) begin
                            r     <= '0;
                            j     <= '0;
                            state <= ST_DATA;
                        end else begin
                            r <= r + 1'b1;
                        end
                    end
                end
                default: state <= ST_DATA;
            endcase
        end
    end

endmodule
